// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry and pixel types shared by the rectangle
// fill engine and the LCD reader side.
//   H_RES, V_RES : framebuffer size in pixels
//   FB_DEPTH     : pixel count, one word per pixel in each byte RAM
//   ADDR_W       : framebuffer address width
//   rgb565_t     : 16-bit colour, r in the MSBs
//   fill_state_t : rectangle fill FSM states
package fb_pkg;

  localparam int H_RES    = 240;
  localparam int V_RES    = 135;
  localparam int FB_DEPTH = H_RES * V_RES;
  localparam int ADDR_W   = 15;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FILL
  } fill_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: clips a rectangle to the framebuffer, then walks it row by
// row producing one pixel address per step.
//   clk, resetn  : clock, asynchronous active-low reset
//   load         : latch x/y and the clipped right/bottom ends
//   x, y, w, h   : rectangle origin and size from the command
//   setup        : compute row_base for the first row, present first address
//   step         : advance to the next pixel (never asserted on the last one)
//   ram_ad       : current pixel address (registered)
//   last         : current pixel is the bottom-right one
module fb_addr_gen #(
  parameter int H_RES  = fb_pkg::H_RES,
  parameter int V_RES  = fb_pkg::V_RES,
  parameter int ADDR_W = fb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  input  logic [7:0]        w,
  input  logic [7:0]        h,
  input  logic              setup,
  input  logic              step,
  output logic [ADDR_W-1:0] ram_ad,
  output logic              last
);

  localparam logic [8:0]        H_END  = 9'(H_RES);
  localparam logic [8:0]        V_END  = 9'(V_RES);
  localparam logic [9:0]        H_BITS = 10'(H_RES);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

  logic [8:0]        x_sum, y_sum, x_end_clip, y_end_clip;
  logic [8:0]        x0, x_end, y_end, col, row;
  logic [ADDR_W-1:0] row_base;

  // row * H_RES without a multiplier: 240 = 256 - 16, other widths fall
  // back to a constant shift-and-add over the set bits of H_RES.
  // Intermediate wrap in ADDR_W bits is harmless since the result fits.
  function automatic logic [ADDR_W-1:0] row_offset(input logic [8:0] r);
    logic [ADDR_W-1:0] rr, acc;
    rr = ADDR_W'(r);
    if (H_RES == 240) begin
      acc = (rr << 8) - (rr << 4);
    end else begin
      acc = '0;
      for (int unsigned i = 0; i < 10; i++)
        if (H_BITS[i]) acc = acc + (rr << i);
    end
    return acc;
  endfunction

  always_comb begin
    x_sum      = {1'b0, x} + {1'b0, w};
    y_sum      = {1'b0, y} + {1'b0, h};
    x_end_clip = (x_sum > H_END) ? H_END : x_sum;
    y_end_clip = (y_sum > V_END) ? V_END : y_sum;
  end

  assign last = ((col + 9'd1) == x_end) && ((row + 9'd1) == y_end);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x0       <= '0;
      x_end    <= '0;
      y_end    <= '0;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      ram_ad   <= '0;
    end else if (load) begin
      x0    <= {1'b0, x};
      col   <= {1'b0, x};
      row   <= {1'b0, y};
      x_end <= x_end_clip;
      y_end <= y_end_clip;
    end else if (setup) begin
      row_base <= row_offset(row);
      ram_ad   <= row_offset(row) + ADDR_W'(x0);
    end else if (step) begin
      if ((col + 9'd1) == x_end) begin
        col      <= x0;
        row      <= row + 9'd1;
        row_base <= row_base + H_STEP;
        ram_ad   <= row_base + H_STEP + ADDR_W'(x0);
      end else begin
        col    <= col + 9'd1;
        ram_ad <= ram_ad + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fb_rect_fill.sv
// fb_rect_fill: fills a clipped rectangle of the framebuffer with one
// RGB565 colour, one pixel write per clock into a pair of byte RAMs.
//   clk, resetn         : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake, ready only while idle
//   cmd_x, cmd_y        : top-left pixel
//   cmd_w, cmd_h        : size in pixels (clipped at the framebuffer edge)
//   cmd_color           : RGB565 fill colour
//   ram_ce, ram_wre     : write strobes to both byte RAMs
//   ram_ad              : pixel address y*H_RES+x
//   ram_din_msb/lsb     : colour bytes for the MSB/LSB RAMs
//   busy                : fill in progress
//   clip_err            : one-cycle pulse when a command is rejected
module fb_rect_fill #(
  parameter int H_RES  = fb_pkg::H_RES,
  parameter int V_RES  = fb_pkg::V_RES,
  parameter int ADDR_W = fb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [7:0]        cmd_w,
  input  logic [7:0]        cmd_h,
  input  logic [15:0]       cmd_color,
  output logic              ram_ce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [7:0]        ram_din_msb,
  output logic [7:0]        ram_din_lsb,
  output logic              busy,
  output logic              clip_err
);

  import fb_pkg::*;

  localparam logic [8:0] H_END = 9'(H_RES);
  localparam logic [8:0] V_END = 9'(V_RES);

  fill_state_t state;
  rgb565_t     color_in;
  logic        accept, reject, wr_en, last;

  assign color_in = cmd_color;
  assign accept   = (state == IDLE) && cmd_ready && cmd_valid;
  assign reject   = (cmd_w == '0) || (cmd_h == '0) ||
                    ({1'b0, cmd_x} >= H_END) || ({1'b0, cmd_y} >= V_END);

  assign ram_ce  = wr_en;
  assign ram_wre = wr_en;

  fb_addr_gen #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk    (clk),
    .resetn (resetn),
    .load   (accept && !reject),
    .x      (cmd_x),
    .y      (cmd_y),
    .w      (cmd_w),
    .h      (cmd_h),
    .setup  (state == SETUP),
    .step   ((state == FILL) && !last),
    .ram_ad (ram_ad),
    .last   (last)
  );

  // A rejected command stays in IDLE but drops cmd_ready for the clip_err
  // cycle; IDLE with cmd_ready low always re-raises it on the next edge,
  // which also gives the one-cycle ready delay after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      clip_err    <= 1'b0;
      wr_en       <= 1'b0;
      ram_din_msb <= '0;
      ram_din_lsb <= '0;
    end else begin
      clip_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            if (reject) begin
              clip_err <= 1'b1;
            end else begin
              state       <= SETUP;
              busy        <= 1'b1;
              ram_din_msb <= {color_in.r, color_in.g[5:3]};
              ram_din_lsb <= {color_in.g[2:0], color_in.b};
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          state <= FILL;
          wr_en <= 1'b1;
        end
        FILL: begin
          if (last) begin
            state     <= IDLE;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
module tb_fb_rect_fill;

  localparam int H = 240;
  localparam int V = 135;
  localparam int BOUND = 2000;

  typedef struct {
    int ad;
    int msb;
    int lsb;
    int cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [15:0] cmd_color = '0;
  logic        ram_ce, ram_wre, busy, clip_err;
  logic [14:0] ram_ad;
  logic [7:0]  ram_din_msb, ram_din_lsb;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  bit  clip_seen = 0;

  fb_rect_fill #(.H_RES(240), .V_RES(135), .ADDR_W(15)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color),
    .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_ad(ram_ad),
    .ram_din_msb(ram_din_msb), .ram_din_lsb(ram_din_lsb),
    .busy(busy), .clip_err(clip_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Write monitor: every write must match the head of the scoreboard,
  // including the cycle it is due on.
  always @(negedge clk) begin
    wr_t e;
    if (clip_err === 1'b1) clip_seen = 1;
    if (ram_wre !== 1'b0) begin
      chk("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", ram_ad, e.ad);
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_msb", ram_din_msb, e.msb);
        chk("wr_lsb", ram_din_lsb, e.lsb);
        chk("wr_ce", ram_ce, 1);
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input logic [7:0] x, y, w, h, input logic [15:0] c,
                      input bit hold, output int acc, output int nw, output bit rej);
    int n, xi, yi, wi, hi, xe, ye;
    n = 0;
    xi = int'(x); yi = int'(y); wi = int'(w); hi = int'(h);
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n < BOUND, 1);
    acc = cyc + 1;
    rej = (wi == 0) || (hi == 0) || (xi >= H) || (yi >= V);
    nw = 0;
    if (!rej) begin
      xe = (xi + wi > H) ? H : xi + wi;
      ye = (yi + hi > V) ? V : yi + hi;
      for (int r = yi; r < ye; r++)
        for (int cl = xi; cl < xe; cl++) begin
          exp_q.push_back('{r * H + cl, int'(c[15:8]), int'(c[7:0]), acc + 1 + nw});
          nw++;
        end
    end
    clip_seen = 0;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input string tag, input int acc, input int nw, input bit rej);
    if (rej) begin
      chk({tag, "_clip_err_hi"}, clip_err, 1);
      chk({tag, "_ready_lo"}, cmd_ready, 0);
      chk({tag, "_busy_lo"}, busy, 0);
      @(negedge clk);
      chk({tag, "_clip_err_lo"}, clip_err, 0);
      chk({tag, "_ready_back"}, cmd_ready, 1);
      chk({tag, "_no_writes"}, exp_q.size(), 0);
    end else begin
      chk({tag, "_busy_setup"}, busy, 1);
      chk({tag, "_ready_setup"}, cmd_ready, 0);
      repeat (nw + 1) @(negedge clk);
      chk({tag, "_done_cycle"}, cyc, acc + nw + 1);
      chk({tag, "_ready_done"}, cmd_ready, 1);
      chk({tag, "_busy_done"}, busy, 0);
      chk({tag, "_wre_done"}, ram_wre, 0);
      chk({tag, "_ce_done"}, ram_ce, 0);
      chk({tag, "_all_written"}, exp_q.size(), 0);
      chk({tag, "_no_clip_err"}, clip_seen, 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, nw, acc_b, nw_b;
    bit rej, rej_b;

    // Reset state
    #1 resetn = 1'b0;
    #1;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clip", clip_err, 0);
    chk("rst_ce", ram_ce, 0);
    chk("rst_wre", ram_wre, 0);
    chk("rst_ad", ram_ad, 0);
    chk("rst_msb", ram_din_msb, 0);
    chk("rst_lsb", ram_din_lsb, 0);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    chk("rel_ready_lo", cmd_ready, 0);
    @(negedge clk);
    chk("rel_ready_hi", cmd_ready, 1);

    // Single pixel at the origin
    send(8'd0, 8'd0, 8'd1, 8'd1, 16'hF034, 0, acc, nw, rej);
    chk("t1_count", nw, 1);
    finish_cmd("t1", acc, nw, rej);

    // 3x2 block
    send(8'd10, 8'd2, 8'd3, 8'd2, 16'h1234, 0, acc, nw, rej);
    finish_cmd("t2", acc, nw, rej);

    // Bottom-right corner, clipped both ways
    send(8'd238, 8'd133, 8'd10, 8'd10, 16'hABCD, 0, acc, nw, rej);
    chk("t3_count", nw, 4);
    finish_cmd("t3", acc, nw, rej);

    // Right edge clip only
    send(8'd235, 8'd7, 8'd20, 8'd2, 16'h07E0, 0, acc, nw, rej);
    finish_cmd("t4", acc, nw, rej);

    // Rejections
    send(8'd5, 8'd5, 8'd0, 8'd3, 16'hFFFF, 0, acc, nw, rej);
    finish_cmd("rej_w0", acc, nw, rej);
    send(8'd240, 8'd5, 8'd3, 8'd3, 16'hFFFF, 0, acc, nw, rej);
    finish_cmd("rej_x240", acc, nw, rej);
    send(8'd5, 8'd135, 8'd3, 8'd3, 16'hFFFF, 0, acc, nw, rej);
    finish_cmd("rej_y135", acc, nw, rej);
    send(8'd5, 8'd5, 8'd3, 8'd0, 16'hFFFF, 0, acc, nw, rej);
    finish_cmd("rej_h0", acc, nw, rej);

    // Back-to-back with cmd_valid held high
    send(8'd20, 8'd50, 8'd2, 8'd2, 16'h5A5A, 1, acc, nw, rej);
    send(8'd100, 8'd100, 8'd3, 8'd1, 16'hC3C3, 0, acc_b, nw_b, rej_b);
    chk("b2b_accept_cycle", acc_b, acc + nw + 2);
    finish_cmd("b2b", acc_b, nw_b, rej_b);

    // Reset in the middle of a full-screen fill
    send(8'd0, 8'd0, 8'd240, 8'd135, 16'h8421, 0, acc, nw, rej);
    repeat (100) @(negedge clk);
    chk("abort_wre_before", ram_wre, 1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_wre_async", ram_wre, 0);
    chk("abort_ce_async", ram_ce, 0);
    chk("abort_ad_async", ram_ad, 0);
    chk("abort_busy_async", busy, 0);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    chk("abort_ready_lo", cmd_ready, 0);
    @(negedge clk);
    chk("abort_ready_hi", cmd_ready, 1);
    repeat (5) @(negedge clk);
    send(8'd3, 8'd4, 8'd2, 8'd2, 16'h0F0F, 0, acc, nw, rej);
    finish_cmd("after_abort", acc, nw, rej);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
